// File: rtl/ub_write_packer.sv
// Packs the int8 activation stream into LANES-byte UB words behind a small FIFO.
// Define UB_PACK_ZERO_FILL_EN to zero the masked-off lanes of partial words.
module ub_write_packer #(
   parameter int LANES      = 4,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [15:0]           elem_count,
   input  logic                  valid_in,
   input  logic signed [7:0]     data_in,
   output logic                  ub_wr_valid,
   input  logic                  ub_wr_ready,
   output logic [ADDR_W-1:0]     ub_wr_addr,
   output logic [8*LANES-1:0]    ub_wr_data,
   output logic [LANES-1:0]      ub_wr_mask,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   // state   | meaning
   // S_IDLE  | waiting for start
   // S_PACK  | accepting elements, pushing words into the FIFO
   // S_DRAIN | all elements pushed, emptying the FIFO to the UB
   // S_DONE  | single-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

   localparam int LW = $clog2(LANES);
   localparam int PW = $clog2(FIFO_DEPTH);

   state_t                                 state_q, state_d;
   logic [LW-1:0]                          lane_q, lane_d;
   logic [15:0]                            remain_q, remain_d;
   logic [ADDR_W-1:0]                      addr_q, addr_d;
   logic [LANES-1:0][7:0]                  pack_q, pack_d;
   logic [FIFO_DEPTH-1:0][8*LANES-1:0]     fifo_data_q, fifo_data_d;
   logic [FIFO_DEPTH-1:0][LANES-1:0]       fifo_mask_q, fifo_mask_d;
   logic [PW:0]                            wr_ptr_q, wr_ptr_d;
   logic [PW:0]                            rd_ptr_q, rd_ptr_d;
   logic                                   overflow_q, overflow_d;
   logic                                   done_q, done_d;
   logic                                   busy_q, busy_d;

   logic                                   fifo_empty, fifo_full, pop, push;
   logic [8*LANES-1:0]                     push_data;
   logic [LANES-1:0]                       push_mask;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop        = ~fifo_empty & ub_wr_ready;

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      remain_d    = remain_q;
      addr_d      = addr_q;
      pack_d      = pack_q;
      fifo_data_d = fifo_data_q;
      fifo_mask_d = fifo_mask_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      push        = 1'b0;
      push_data   = '0;
      push_mask   = '0;

      if (pop) begin
         rd_ptr_d = rd_ptr_q + (PW+1)'(1);
         addr_d   = addr_q + ADDR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               overflow_d = 1'b0;
               addr_d     = base_addr;
               remain_d   = elem_count;
               lane_d     = '0;
`ifdef UB_PACK_ZERO_FILL_EN
               pack_d     = '0;
`endif
               state_d    = (elem_count == 16'd0) ? S_DONE : S_PACK;
            end
         end
         S_PACK: begin
            if (valid_in) begin
               pack_d[lane_q] = data_in;
               remain_d       = remain_q - 16'd1;
               if (lane_q == LW'(LANES-1) || remain_q == 16'd1) begin
                  push      = 1'b1;
                  push_data = pack_d;
                  for (int k = 0; k < LANES; k++) begin
                     push_mask[k] = (LW'(k) <= lane_q);
`ifdef UB_PACK_ZERO_FILL_EN
                     if (LW'(k) > lane_q) push_data[8*k +: 8] = '0;
`endif
                  end
`ifdef UB_PACK_ZERO_FILL_EN
                  pack_d = '0;
`endif
                  lane_d = '0;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
               if (remain_q == 16'd1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // look at the post-pop pointer so done follows the final handshake directly
            if (rd_ptr_d == wr_ptr_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         if (!fifo_full || pop) begin
            fifo_data_d[wr_ptr_q[PW-1:0]] = push_data;
            fifo_mask_d[wr_ptr_q[PW-1:0]] = push_mask;
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         lane_q      <= '0;
         remain_q    <= '0;
         addr_q      <= '0;
         pack_q      <= '0;
         fifo_data_q <= '0;
         fifo_mask_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         remain_q    <= remain_d;
         addr_q      <= addr_d;
         pack_q      <= pack_d;
         fifo_data_q <= fifo_data_d;
         fifo_mask_q <= fifo_mask_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign ub_wr_valid = ~fifo_empty;
   assign ub_wr_addr  = addr_q;
   assign ub_wr_data  = fifo_empty ? '0 : fifo_data_q[rd_ptr_q[PW-1:0]];
   assign ub_wr_mask  = fifo_empty ? '0 : fifo_mask_q[rd_ptr_q[PW-1:0]];
   assign busy        = busy_q;
   assign done        = done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ub_write_packer.sv
// Directed bench for ub_write_packer: packing, partial masks, wrap, overflow, reset.
module tb_ub_write_packer;
   localparam int LANES  = 4;
   localparam int ADDR_W = 10;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic [ADDR_W-1:0]   base_addr = '0;
   logic [15:0]         elem_count = '0;
   logic                valid_in = 1'b0;
   logic signed [7:0]   data_in = '0;
   logic                ub_wr_valid;
   logic                ub_wr_ready = 1'b1;
   logic [ADDR_W-1:0]   ub_wr_addr;
   logic [8*LANES-1:0]  ub_wr_data;
   logic [LANES-1:0]    ub_wr_mask;
   logic                busy, done, overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [ADDR_W-1:0]   wq_addr[$];
   logic [8*LANES-1:0]  wq_data[$];
   logic [LANES-1:0]    wq_mask[$];

   ub_write_packer #(.LANES(LANES), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .elem_count(elem_count), .valid_in(valid_in), .data_in(data_in),
      .ub_wr_valid(ub_wr_valid), .ub_wr_ready(ub_wr_ready), .ub_wr_addr(ub_wr_addr),
      .ub_wr_data(ub_wr_data), .ub_wr_mask(ub_wr_mask), .busy(busy), .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ub_wr_valid && ub_wr_ready) begin
         wq_addr.push_back(ub_wr_addr);
         wq_data.push_back(ub_wr_data);
         wq_mask.push_back(ub_wr_mask);
      end
      if (done) done_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      wq_mask.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [15:0] n);
      start = 1'b1; base_addr = b; elem_count = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic stream(input int n, input logic [7:0] b0);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(int'(b0) + i);
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
   endtask

   // waits for done, then one more cycle so the FSM is back in IDLE
   task automatic wait_done(input string tag, input int max_cyc);
      int seen;
      seen = 0;
      for (int c = 0; c < max_cyc && seen == 0; c++) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_write(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                              input logic [8*LANES-1:0] d, input logic [8*LANES-1:0] dmask,
                              input logic [LANES-1:0] m);
      if (idx < wq_addr.size()) begin
         check_val({tag, "_addr"}, 64'(wq_addr[idx]), 64'(a));
         check_val({tag, "_data"}, 64'(wq_data[idx] & dmask), 64'(d & dmask));
         check_val({tag, "_mask"}, 64'(wq_mask[idx]), 64'(m));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_valid"}, 64'(ub_wr_valid), 64'd0);
      check_val({tag, "_addr"},  64'(ub_wr_addr),  64'd0);
      check_val({tag, "_data"},  64'(ub_wr_data),  64'd0);
      check_val({tag, "_mask"},  64'(ub_wr_mask),  64'd0);
      check_val({tag, "_busy"},  64'(busy),        64'd0);
      check_val({tag, "_done"},  64'(done),        64'd0);
      check_val({tag, "_ovf"},   64'(overflow),    64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("rst");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // full words, latency and done timing
      clear_log();
      do_start(10'h010, 16'd8);
      check_val("t1_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(i + 1);
         @(posedge clk); #1;
         if (i == 2) check_val("t1_lat_before", 64'(ub_wr_valid), 64'd0);
         if (i == 3) check_val("t1_lat_after", 64'(ub_wr_valid), 64'd1);
      end
      valid_in = 1'b0;
      check_val("t1_done_early", 64'(done), 64'd0);
      @(posedge clk); #1;
      check_val("t1_done", 64'(done), 64'd1);
      check_val("t1_busy_done", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check_val("t1_done_off", 64'(done), 64'd0);
      check_val("t1_busy_off", 64'(busy), 64'd0);
      check_val("t1_nwr", 64'(wq_addr.size()), 64'd2);
      check_val("t1_ndone", 64'(done_cnt), 64'd1);
      check_write("t1_w0", 0, 10'h010, 32'h04030201, 32'hFFFFFFFF, 4'hF);
      check_write("t1_w1", 1, 10'h011, 32'h08070605, 32'hFFFFFFFF, 4'hF);

      // partial final group
      clear_log();
      do_start(10'h010, 16'd6);
      stream(6, 8'h11);
      wait_done("t2", 20);
      check_val("t2_nwr", 64'(wq_addr.size()), 64'd2);
      check_write("t2_w0", 0, 10'h010, 32'h14131211, 32'hFFFFFFFF, 4'hF);
      check_write("t2_w1", 1, 10'h011, 32'h00001615, 32'h0000FFFF, 4'h3);
`ifdef UB_PACK_ZERO_FILL_EN
      check_write("t2_w1_zf", 1, 10'h011, 32'h00001615, 32'hFFFFFFFF, 4'h3);
`endif

      // address wrap
      clear_log();
      do_start(10'h3FF, 16'd8);
      stream(8, 8'h21);
      wait_done("t3", 20);
      check_val("t3_nwr", 64'(wq_addr.size()), 64'd2);
      check_write("t3_w0", 0, 10'h3FF, 32'h24232221, 32'hFFFFFFFF, 4'hF);
      check_write("t3_w1", 1, 10'h000, 32'h28272625, 32'hFFFFFFFF, 4'hF);

      // backpressure and overflow
      clear_log();
      ub_wr_ready = 1'b0;
      do_start(10'h100, 16'd24);
      stream(24, 8'h40);
      repeat (16) @(posedge clk);
      #1;
      check_val("t4_ovf", 64'(overflow), 64'd1);
      check_val("t4_stall_valid", 64'(ub_wr_valid), 64'd1);
      check_val("t4_stall_addr", 64'(ub_wr_addr), 64'h100);
      check_val("t4_stall_data", 64'(ub_wr_data), 64'h43424140);
      check_val("t4_busy", 64'(busy), 64'd1);
      ub_wr_ready = 1'b1;
      wait_done("t4", 20);
      check_val("t4_nwr", 64'(wq_addr.size()), 64'd4);
      check_write("t4_w0", 0, 10'h100, 32'h43424140, 32'hFFFFFFFF, 4'hF);
      check_write("t4_w1", 1, 10'h101, 32'h47464544, 32'hFFFFFFFF, 4'hF);
      check_write("t4_w2", 2, 10'h102, 32'h4B4A4948, 32'hFFFFFFFF, 4'hF);
      check_write("t4_w3", 3, 10'h103, 32'h4F4E4D4C, 32'hFFFFFFFF, 4'hF);
      check_val("t4_ovf_sticky", 64'(overflow), 64'd1);

      // zero-length transfer
      clear_log();
      do_start(10'h055, 16'd0);
      check_val("t5_done", 64'(done), 64'd1);
      check_val("t5_busy", 64'(busy), 64'd1);
      check_val("t5_ovf_clr", 64'(overflow), 64'd0);
      @(posedge clk); #1;
      check_val("t5_done_off", 64'(done), 64'd0);
      check_val("t5_busy_off", 64'(busy), 64'd0);
      check_val("t5_nwr", 64'(wq_addr.size()), 64'd0);

      // start while busy is ignored
      clear_log();
      do_start(10'h200, 16'd8);
      stream(4, 8'h51);
      do_start(10'h050, 16'd2);
      stream(4, 8'h55);
      wait_done("t6", 20);
      check_val("t6_nwr", 64'(wq_addr.size()), 64'd2);
      check_val("t6_ndone", 64'(done_cnt), 64'd1);
      check_write("t6_w0", 0, 10'h200, 32'h54535251, 32'hFFFFFFFF, 4'hF);
      check_write("t6_w1", 1, 10'h201, 32'h58575655, 32'hFFFFFFFF, 4'hF);

      // reset mid-transfer
      clear_log();
      do_start(10'h020, 16'd8);
      stream(3, 8'h71);
      check_val("t7_busy_pre", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("t7_rst");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      stream(5, 8'h74);
      repeat (4) @(posedge clk);
      #1;
      check_val("t7_nwr_after_rst", 64'(wq_addr.size()), 64'd0);
      check_val("t7_busy_after_rst", 64'(busy), 64'd0);
      do_start(10'h030, 16'd4);
      stream(4, 8'h61);
      wait_done("t7", 20);
      check_val("t7_nwr", 64'(wq_addr.size()), 64'd1);
      check_write("t7_w0", 0, 10'h030, 32'h64636261, 32'hFFFFFFFF, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ub_write_packer.md
# ub_write_packer

Packs the int8 stream from the activation pipeline (`valid_out` / `ub_data_out`) into LANES-byte words and writes them to the unified buffer over a valid/ready write port. It generates sequential addresses from a programmed base and issues a masked partial word for a final, incomplete group. A small FIFO absorbs UB backpressure, because the upstream pipeline cannot stall.

## Interface
- `LANES`, 4: int8 elements per UB word; power of two, at least 2.
- `ADDR_W`, 10: UB word-address width.
- `FIFO_DEPTH`, 4: packed-word FIFO entries; power of two, at least 2.

- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches `base_addr` and `elem_count`. Honoured only in IDLE.
- `base_addr`  in  ADDR_W  UB word address of the first write.
- `elem_count`  in  16  number of int8 elements in this transfer.
- `valid_in`  in  1  input element strobe; no backpressure.
- `data_in`  in  8 (signed)  quantized element.
- `ub_wr_valid`  out  1  write request.
- `ub_wr_ready`  in  1  UB accepts the write.
- `ub_wr_addr`  out  ADDR_W  write word address.
- `ub_wr_data`  out  8*LANES  packed word; element k of the group sits at bits [8k+7:8k].
- `ub_wr_mask`  out  LANES  byte enables; bit k = lane k valid.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `overflow`  out  1  sticky; a packed word was dropped. Cleared by `start` or reset.

## Operation
- FSM states: IDLE, PACK, DRAIN, DONE.
- IDLE → PACK on `start` when `elem_count` is not 0. IDLE → DONE on `start` when `elem_count` is 0; no writes are issued.
- PACK:
  - Each `valid_in` writes `data_in` into lane `lane_cnt` of the pack register and decrements the remaining count.
  - When `lane_cnt` reaches LANES-1, or the last element arrives, push {data, mask} to the FIFO and reset `lane_cnt` to 0.
- After the last element is pushed: PACK → DRAIN.
- DRAIN → DONE when the FIFO is empty and no write is pending.
- DONE → IDLE after one cycle; `done` is high for exactly that cycle.
- `valid_in` outside PACK is ignored. `start` outside IDLE is ignored.
- The FIFO head drives `ub_wr_data` and `ub_wr_mask`; `ub_wr_valid` = FIFO not empty.
- On the `ub_wr_valid & ub_wr_ready` handshake, pop the FIFO and increment the address.
  - The address wraps modulo 2^ADDR_W with no error.
  - `ub_wr_addr` is the address of the current head word.
- Data, mask and address stay stable while `ub_wr_valid` is high and `ub_wr_ready` is low.
- Push attempted while the FIFO is full with no pop in the same cycle: the word is dropped, `overflow` sets, and the address is not advanced for it.
- Push while full with a simultaneous pop: accepted, no overflow.
- Word mask: a full group gets mask all-ones. A final partial group of r elements gets mask (1<<r)-1.
- `busy` is high from the cycle after the accepted `start` through the `done` cycle, inclusive.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low): `ub_wr_valid`=0, `ub_wr_addr`=0, `ub_wr_data`=0, `ub_wr_mask`=0, `busy`=0, `done`=0, `overflow`=0. FSM goes to IDLE and the FIFO empties.
- Reset mid-transfer: the transfer is abandoned; no further writes are issued after reset is released.
- Latency: the completing element is presented in cycle N; `ub_wr_valid` is high in cycle N+1 when the FIFO was empty.
- Throughput: 1 word/cycle while `ub_wr_ready`=1, which exceeds the input rate of 1 element/cycle.
- `done` is asserted in the cycle after the final write handshake (DRAIN → DONE). For `elem_count`=0, `done` is asserted the cycle after `start`.
- `start` and `valid_in` in the same cycle: `valid_in` is ignored.

## Configuration
- `UB_PACK_ZERO_FILL_EN`:
  - Defined: masked-off lanes of a partial word are driven to 0, and the pack register clears on each push.
  - Not defined: masked-off lanes carry the previous contents of the pack register. Only `ub_wr_mask` guarantees validity.

## Test plan
- `base_addr`=0x010, `elem_count`=8, bytes 0x01..0x08 back-to-back, `ub_wr_ready`=1 → writes 0x04030201 @0x010 and 0x08070605 @0x011, mask 0xF, then a single `done` pulse.
- `elem_count`=6, bytes 0x11..0x16 → second write 0x????1615 @0x011 with mask 0x3. With `UB_PACK_ZERO_FILL_EN` the upper bytes read 0x0000.
- `base_addr`=0x3FF, `elem_count`=8 → addresses 0x3FF then 0x000; no error.
- `ub_wr_ready`=0 for 40 cycles while 24 bytes stream in → exactly 4 words queued, 2 words dropped, `overflow`=1. After `ready` rises, the 4 words are written at consecutive addresses.
- `elem_count`=0 → `done` the cycle after `start`, `ub_wr_valid` never asserted. A `start` while `busy` has no effect.
- `reset_n` low after 3 of 8 bytes → all outputs 0 immediately. A new `start` after release produces a correct, fresh transfer.
